// File: rtl/seg_capture_pkg.sv
// Shared constants, glyph table and dwell state type for the seven-segment scan capture block.
package seg_capture_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low gfedcba patterns
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } dwell_state_t;

    function automatic logic one_low(input logic [7:0] an);
        logic [7:0] z;
        z = ~an;
        return (z != 8'h00) && ((z & (z - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] low_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational decode of an active-low 7-segment pattern back to its hex nibble.
module seg7_glyph_decode
    import seg_capture_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_ok,
    output logic [3:0] o_nibble
);

    // Pattern lookup; anything outside the 16 hex glyphs is flagged not ok
    always_comb begin
        o_ok     = 1'b1;
        o_nibble = 4'h0;
        case (i_pattern)
            GLYPH_0: o_nibble = 4'h0;
            GLYPH_1: o_nibble = 4'h1;
            GLYPH_2: o_nibble = 4'h2;
            GLYPH_3: o_nibble = 4'h3;
            GLYPH_4: o_nibble = 4'h4;
            GLYPH_5: o_nibble = 4'h5;
            GLYPH_6: o_nibble = 4'h6;
            GLYPH_7: o_nibble = 4'h7;
            GLYPH_8: o_nibble = 4'h8;
            GLYPH_9: o_nibble = 4'h9;
            GLYPH_A: o_nibble = 4'hA;
            GLYPH_B: o_nibble = 4'hB;
            GLYPH_C: o_nibble = 4'hC;
            GLYPH_D: o_nibble = 4'hD;
            GLYPH_E: o_nibble = 4'hE;
            GLYPH_F: o_nibble = 4'hF;
            default: begin
                o_ok     = 1'b0;
                o_nibble = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a scanned seven-segment display, decodes stable digits and rebuilds the 8-digit value.
// Optional macro SEG_CAPTURE_DP_EN: decimal point joins the dwell compare and is captured to dp.
module seg_scan_capture
    import seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [7:0]  SEG,
    input  logic [7:0]  AN,
    output logic [31:0] value,
    output logic [7:0]  dp,
    output logic        value_valid,
    input  logic        value_ack,
    output logic        bad_glyph,
    output logic        overrun
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [7:0]   r_seg;
    logic [7:0]   r_an;
    logic [15:0]  r_key;
    dwell_state_t r_state;
    dwell_state_t w_state_n;
    logic [7:0]   r_cnt;
    logic [7:0]   w_cnt_n;
    logic         w_accept;
    logic [7:0]   r_seen;
    logic [7:0]   w_seen_n;
    logic [31:0]  r_shadow_val;
    logic [7:0]   r_shadow_dp;
    logic         w_dp_bit;
    logic [15:0]  w_key;
    logic         w_same;
    logic         w_digit;
    logic         w_ok;
    logic         w_frame_done;
    logic [2:0]   w_idx;
    logic [3:0]   w_nib;

`ifdef SEG_CAPTURE_DP_EN
    assign w_dp_bit = ~r_seg[7];
    assign w_key    = {r_an, r_seg};
`else
    logic w_unused_dp;
    assign w_unused_dp = r_seg[7];
    assign w_dp_bit    = 1'b0;
    assign w_key       = {r_an, 1'b1, r_seg[6:0]};
`endif

    assign w_same       = (w_key == r_key);
    assign w_digit      = one_low(r_an);
    assign w_idx        = low_index(r_an);
    assign w_frame_done = (r_seen == 8'hFF);
    // During an accept r_an has a single zero, so its inverse is the digit's one-hot mask
    assign w_seen_n     = (w_frame_done ? 8'h00 : r_seen) | ((w_accept && w_ok) ? ~r_an : 8'h00);

    seg7_glyph_decode u_decode (
        .i_pattern (r_seg[6:0]),
        .o_ok      (w_ok),
        .o_nibble  (w_nib)
    );

    // Input sample register and previous-sample key for the stability compare
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_seg <= 8'hFF;
            r_an  <= 8'hFF;
            r_key <= 16'hFFFF;
        end else begin
            r_seg <= SEG;
            r_an  <= AN;
            r_key <= w_key;
        end
    end

    // Dwell FSM state and saturating stability counter
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= BLANK;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Dwell next-state: a digit is accepted exactly once, on the sample that makes cnt reach STABLE
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_accept  = 1'b0;
        case (r_state)
            BLANK: begin
                if (w_digit) begin
                    w_state_n = DWELL;
                    w_cnt_n   = 8'd1;
                end else begin
                    w_state_n = BLANK;
                    w_cnt_n   = 8'd0;
                end
            end
            DWELL, HELD: begin
                if (w_same && (r_state == HELD)) begin
                    w_state_n = HELD;
                    w_cnt_n   = STABLE;
                end else if (w_same) begin
                    if ((r_cnt + 8'd1) >= STABLE) begin
                        w_state_n = HELD;
                        w_cnt_n   = STABLE;
                        w_accept  = 1'b1;
                    end else begin
                        w_state_n = DWELL;
                        w_cnt_n   = r_cnt + 8'd1;
                    end
                end else if (w_digit) begin
                    w_state_n = DWELL;
                    w_cnt_n   = 8'd1;
                end else begin
                    w_state_n = BLANK;
                    w_cnt_n   = 8'd0;
                end
            end
            default: begin
                w_state_n = BLANK;
                w_cnt_n   = 8'd0;
            end
        endcase
    end

    // Shadow frame, seen mask and sticky bad-glyph flag
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_seen       <= 8'h00;
            r_shadow_val <= 32'h0000_0000;
            r_shadow_dp  <= 8'h00;
            bad_glyph    <= 1'b0;
        end else begin
            r_seen <= w_seen_n;
            if (w_accept && w_ok) begin
                r_shadow_val[{w_idx, 2'b00} +: 4] <= w_nib;
                r_shadow_dp[w_idx]                <= w_dp_bit;
            end
            if (w_accept && !w_ok) begin
                bad_glyph <= 1'b1;
            end
        end
    end

    // Output frame and valid/ack handshake; a completion with an unacked frame pending is an overrun
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            value       <= 32'h0000_0000;
            dp          <= 8'h00;
            value_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (w_frame_done) begin
            if (!value_valid || value_ack) begin
                value       <= r_shadow_val;
                dp          <= r_shadow_dp;
                value_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (value_valid && value_ack) begin
            value_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: a vector table for the main scan sequence plus hand-written corner sequences.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        value_ack;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        value_valid;
    logic        bad_glyph;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .RST         (RST),
        .SEG         (SEG),
        .AN          (AN),
        .value       (value),
        .dp          (dp),
        .value_valid (value_valid),
        .value_ack   (value_ack),
        .bad_glyph   (bad_glyph),
        .overrun     (overrun)
    );

    typedef struct {
        logic [7:0]  an;
        logic [7:0]  seg;
        logic        ack;
        int          cycles;
        logic        exp_valid;
        logic [31:0] exp_value;
        logic        exp_bad;
        logic        exp_ovr;
    } vec_t;

    vec_t tbl [0:20];

`ifdef SEG_CAPTURE_DP_EN
    localparam logic [7:0] EXP_DP4 = 8'h10;
`else
    localparam logic [7:0] EXP_DP4 = 8'h00;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] an_sel(input int idx);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << idx);
    endfunction

    task automatic drive(input logic [7:0] an, input logic [7:0] seg, input logic ack, input int n);
        AN        = an;
        SEG       = seg;
        value_ack = ack;
        repeat (n) @(negedge clk);
        value_ack = 1'b0;
    endtask

    task automatic scan(input int idx, input logic [7:0] seg, input int n);
        drive(an_sel(idx), seg, 1'b0, n);
    endtask

    task automatic set_row(input int i, input logic [7:0] an, input logic [7:0] seg, input logic ack,
                           input int n, input logic v, input logic [31:0] val);
        tbl[i].an        = an;
        tbl[i].seg       = seg;
        tbl[i].ack       = ack;
        tbl[i].cycles    = n;
        tbl[i].exp_valid = v;
        tbl[i].exp_value = val;
        tbl[i].exp_bad   = 1'b0;
        tbl[i].exp_ovr   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_value"}, value, 32'h0);
        check({tag, "_dp"}, {24'h0, dp}, 32'h0);
        check({tag, "_valid"}, {31'h0, value_valid}, 32'h0);
        check({tag, "_bad"}, {31'h0, bad_glyph}, 32'h0);
        check({tag, "_ovr"}, {31'h0, overrun}, 32'h0);
    endtask

    initial begin
        // Normal frame 1234ABCD, ack, glitch on digit 2, two-anode sample, then a frame needing digit 2
        set_row(0,  an_sel(7), 8'hF9, 1'b0, 8, 1'b0, 32'h0);
        set_row(1,  an_sel(6), 8'hA4, 1'b0, 8, 1'b0, 32'h0);
        set_row(2,  an_sel(5), 8'hB0, 1'b0, 8, 1'b0, 32'h0);
        set_row(3,  an_sel(4), 8'h99, 1'b0, 8, 1'b0, 32'h0);
        set_row(4,  an_sel(3), 8'h88, 1'b0, 8, 1'b0, 32'h0);
        set_row(5,  an_sel(2), 8'h83, 1'b0, 8, 1'b0, 32'h0);
        set_row(6,  an_sel(1), 8'hC6, 1'b0, 8, 1'b0, 32'h0);
        set_row(7,  an_sel(0), 8'hA1, 1'b0, 8, 1'b1, 32'h1234ABCD);
        set_row(8,  8'hFF,     8'hFF, 1'b1, 1, 1'b0, 32'h1234ABCD);
        set_row(9,  an_sel(2), 8'h92, 1'b0, 3, 1'b0, 32'h1234ABCD);
        set_row(10, 8'hFF,     8'hFF, 1'b0, 4, 1'b0, 32'h1234ABCD);
        set_row(11, 8'hFC,     8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(12, an_sel(7), 8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(13, an_sel(6), 8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(14, an_sel(5), 8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(15, an_sel(4), 8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(16, an_sel(3), 8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(17, an_sel(1), 8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(18, an_sel(0), 8'hC0, 1'b0, 8, 1'b0, 32'h1234ABCD);
        set_row(19, an_sel(2), 8'h92, 1'b0, 8, 1'b1, 32'h00000500);
        set_row(20, 8'hFF,     8'hFF, 1'b1, 1, 1'b0, 32'h00000500);

        RST       = 1'b1;
        AN        = 8'hFF;
        SEG       = 8'hFF;
        value_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        RST = 1'b0;
        @(negedge clk);

        for (int i = 0; i <= 20; i++) begin
            drive(tbl[i].an, tbl[i].seg, tbl[i].ack, tbl[i].cycles);
            check($sformatf("row%0d_valid", i), {31'h0, value_valid}, {31'h0, tbl[i].exp_valid});
            check($sformatf("row%0d_value", i), value, tbl[i].exp_value);
            check($sformatf("row%0d_bad", i), {31'h0, bad_glyph}, {31'h0, tbl[i].exp_bad});
            check($sformatf("row%0d_ovr", i), {31'h0, overrun}, {31'h0, tbl[i].exp_ovr});
        end

        // Exact latency: digit 0 appears, accepted 4 edges later, frame out one edge after that
        for (int d = 7; d >= 1; d--) scan(d, 8'hF9, 8);
        AN  = an_sel(0);
        SEG = 8'hF9;
        repeat (5) @(negedge clk);
        check("lat_not_yet", {31'h0, value_valid}, 32'h0);
        @(negedge clk);
        check("lat_valid", {31'h0, value_valid}, 32'h1);
        check("lat_value", value, 32'h11111111);
        repeat (2) @(negedge clk);

        // Second frame with no ack: old frame kept, overrun set
        for (int d = 7; d >= 0; d--) scan(d, 8'hA4, 8);
        check("ovr_value", value, 32'h11111111);
        check("ovr_valid", {31'h0, value_valid}, 32'h1);
        check("ovr_flag", {31'h0, overrun}, 32'h1);

        // Ack on the completion edge: new frame loads and valid stays high
        for (int d = 7; d >= 1; d--) scan(d, 8'hA4, 8);
        AN  = an_sel(0);
        SEG = 8'hA4;
        repeat (5) @(negedge clk);
        value_ack = 1'b1;
        @(negedge clk);
        value_ack = 1'b0;
        check("ackdone_valid", {31'h0, value_valid}, 32'h1);
        check("ackdone_value", value, 32'h22222222);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-frame, then a full new frame must be needed
        for (int d = 7; d >= 3; d--) scan(d, 8'hB0, 8);
        #2 RST = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_hold");
        RST = 1'b0;
        scan(2, 8'hC0, 8);
        scan(1, 8'hC0, 8);
        scan(0, 8'hC0, 8);
        for (int d = 7; d >= 4; d--) scan(d, 8'hC0, 8);
        check("rst_partial_valid", {31'h0, value_valid}, 32'h0);
        scan(3, 8'hC0, 8);
        check("rst_full_valid", {31'h0, value_valid}, 32'h1);
        check("rst_full_value", value, 32'h0);

        // Unrecognised glyph on digit 3: flagged, digit 3 stays unseen
        drive(8'hFF, 8'hFF, 1'b1, 1);
        check("ack_clears", {31'h0, value_valid}, 32'h0);
        scan(3, 8'hFF, 8);
        check("bad_flag", {31'h0, bad_glyph}, 32'h1);
        for (int d = 7; d >= 0; d--) begin
            if (d != 3) scan(d, 8'h99, 8);
        end
        check("bad_no_frame", {31'h0, value_valid}, 32'h0);
        scan(3, 8'h99, 8);
        check("bad_then_frame", {31'h0, value_valid}, 32'h1);
        check("bad_then_value", value, 32'h44444444);

        // Decimal point on digit 4
        drive(8'hFF, 8'hFF, 1'b1, 1);
        for (int d = 7; d >= 0; d--) scan(d, (d == 4) ? 8'h79 : 8'hC0, 8);
        check("dp_valid", {31'h0, value_valid}, 32'h1);
        check("dp_value", value, 32'h00010000);
        check("dp_bits", {24'h0, dp}, {24'h0, EXP_DP4});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
